// File: rtl/knn_buf_pkg.sv
// knn_buf_pkg: shared types, default sizes and helpers for the kNN local buffer sequencer
// Contents: state_t (IDLE/FILL/DRAIN/FIN), DATA_W_DEF, ADDR_RANGE_DEF, clog2()
package knn_buf_pkg;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, FIN} state_t;

   localparam int DATA_W_DEF     = 256;
   localparam int ADDR_RANGE_DEF = 2048;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/knn_buf_skid_fifo.sv
// knn_buf_skid_fifo: small synchronous FIFO absorbing buffer read returns ahead of the drain stream
// Ports: clk, reset (async, active-high), push/din write side, pop/dout read side (dout = head),
//        count = occupancy, empty = no entries. Push on full and pop on empty are not guarded.
module knn_buf_skid_fifo
   import knn_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 256,
   localparam int CW = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [WIDTH-1:0] buf_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // pointers wrap explicitly so DEPTH need not be a power of two
   always_comb begin
      wp_d  = push ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
      rp_d  = pop ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_q[wp_q] <= din;
   end

   assign dout  = buf_q[rp_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/knn_local_buf_seq.sv
// knn_local_buf_seq: fills a single-port local buffer from a stream, then replays it with backpressure
// Ports: clk, reset (async, active-high); start/num_words launch a job, busy/done report it;
//        in_* is the fill stream, out_* the drain stream; mem_* drive the buffer port, mem_q0 returns reads.
module knn_local_buf_seq
   import knn_buf_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_RANGE = ADDR_RANGE_DEF,
   parameter int ADDR_W     = clog2(ADDR_RANGE),
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = RD_LAT + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] mem_address0,
   output logic              mem_ce0,
   output logic              mem_we0,
   output logic [DATA_W-1:0] mem_d0,
   input  logic [DATA_W-1:0] mem_q0
);

   localparam int LW  = ADDR_W + 1;
   localparam int FCW = clog2(FIFO_DEPTH + 1);
   localparam int IW  = clog2(FIFO_DEPTH + RD_LAT + 1);

   state_t            state_q, state_d;
   logic [LW-1:0]     len_q, len_d, wr_q, wr_d, rd_q, rd_d, acc_q, acc_d, len_clamp;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic              done_q, done_d;
   logic [FCW-1:0]    fifo_cnt;
   logic              fifo_empty;
   logic [IW-1:0]     inflight;
   logic              wr_fire, rd_fire, push, pop;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      acc_d     = acc_q;
      done_d    = (state_q == FIN);
      len_clamp = (num_words > LW'(ADDR_RANGE)) ? LW'(ADDR_RANGE) : num_words;
      in_ready  = (state_q == FILL);
      wr_fire   = in_ready && in_valid;
      // credit = reads still in the memory pipe plus words parked in the FIFO
      inflight  = IW'(fifo_cnt);
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(vld_q[i]);
      rd_fire   = (state_q == DRAIN) && (rd_q < len_q) && (inflight < IW'(FIFO_DEPTH));
      pop       = !fifo_empty && out_ready;
      // the oldest in-flight read returns on mem_q0 this cycle
      push      = vld_q[RD_LAT-1];
      vld_d     = RD_LAT'({vld_q, rd_fire});
      case (state_q)
         IDLE: if (start) begin
            len_d   = len_clamp;
            wr_d    = '0;
            state_d = (len_clamp == '0) ? FIN : FILL;
         end
         FILL: if (wr_fire) begin
            wr_d = wr_q + LW'(1);
            if (wr_q == len_q - LW'(1)) begin
               state_d = DRAIN;
               rd_d    = '0;
               acc_d   = '0;
            end
         end
         DRAIN: begin
            if (rd_fire) rd_d = rd_q + LW'(1);
            if (pop) begin
               acc_d = acc_q + LW'(1);
               if (acc_q == len_q - LW'(1)) state_d = FIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         acc_q   <= '0;
         vld_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         acc_q   <= acc_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   knn_buf_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (mem_q0),
      .pop   (pop),
      .dout  (out_data),
      .count (fifo_cnt),
      .empty (fifo_empty)
   );

   assign busy         = (state_q == FILL) || (state_q == DRAIN);
   assign done         = done_q;
   assign out_valid    = !fifo_empty;
   assign mem_ce0      = wr_fire || rd_fire;
   assign mem_we0      = wr_fire;
   assign mem_address0 = wr_fire ? wr_q[ADDR_W-1:0] : (rd_fire ? rd_q[ADDR_W-1:0] : '0);
   assign mem_d0       = in_data;

endmodule
